stage_fetch_queue: RTL

// Line-based instruction fetch stage with a decoupling instruction queue; successor to the single-word fetch stage.

---
 rtl/stage_fetch_queue_if.sv | 32 +++
 rtl/stage_fetch_queue.sv | 135 +++++++++++++
 2 files changed

// File: rtl/stage_fetch_queue_if.sv
// Signal bundle between the line fetch stage, decode, the redirect source and the icache line port.
// master is the fetch stage's view; slave is the view of whatever drives it (decode, memory, bench).
interface stage_fetch_queue_if #(
  parameter int CACHE_LINE_SIZE = 128
);
  logic                       in_redirect;
  logic [31:0]                in_redirect_pc;
  logic                       in_ready;
  logic [CACHE_LINE_SIZE-1:0] in_mem_read_data;
  logic                       in_mem_ready;
  logic                       out_valid;
  logic [31:0]                out_PC;
  logic [31:0]                out_instruction;
  logic [2:0]                 out_exception_vector;
  logic                       out_busy;
  logic                       out_mem_read_en;
  logic                       out_mem_write_en;
  logic [31:0]                out_mem_addr;
  logic [CACHE_LINE_SIZE-1:0] out_mem_write_data;

  modport master (
    input  in_redirect, in_redirect_pc, in_ready, in_mem_read_data, in_mem_ready,
    output out_valid, out_PC, out_instruction, out_exception_vector, out_busy,
           out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data
  );

  modport slave (
    output in_redirect, in_redirect_pc, in_ready, in_mem_read_data, in_mem_ready,
    input  out_valid, out_PC, out_instruction, out_exception_vector, out_busy,
           out_mem_read_en, out_mem_write_en, out_mem_addr, out_mem_write_data
  );
endinterface

// File: rtl/stage_fetch_queue.sv
// Line-based fetch stage: one buffered cache line is sliced into 32-bit words and fed
// through a small instruction queue to decode; redirects flush the queue in one cycle.
module stage_fetch_queue #(
  parameter int          CACHE_LINE_SIZE = 128,
  parameter int          FETCH_DEPTH     = 4,
  parameter logic [31:0] INIT_ADDR       = 32'h200
) (
  input logic                 clk,
  input logic                 reset,
  stage_fetch_queue_if.master bus
);
  localparam int WPL      = CACHE_LINE_SIZE / 32;
  localparam int IDX_BITS = $clog2(WPL);
  localparam int OFF_BITS = IDX_BITS + 2;
  localparam int TAG_BITS = 32 - OFF_BITS;
  localparam int PTR_W    = $clog2(FETCH_DEPTH);

  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(FETCH_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [31:0]      NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DISCARD} state_t;

  state_t                     state, state_next;
  logic [31:0]                fetch_pc;
  logic [31:0]                req_addr;
  logic [CACHE_LINE_SIZE-1:0] line_buf;
  logic [TAG_BITS-1:0]        line_tag;
  logic                       line_valid;
  logic                       halted;

  logic [31:0]                q_pc    [FETCH_DEPTH];
  logic [31:0]                q_instr [FETCH_DEPTH];
  logic [2:0]                 q_exc   [FETCH_DEPTH];
  logic [PTR_W-1:0]           rd_ptr, wr_ptr;
  logic [PTR_W:0]             count;

  logic                       hit, misaligned, has_entry, pop, push, install, start_req;
  logic [IDX_BITS-1:0]        word_idx;
  logic [31:0]                line_word, push_instr;
  logic [2:0]                 push_exc;

  assign hit        = line_valid && (fetch_pc[31:OFF_BITS] == line_tag);
  assign misaligned = fetch_pc[1:0] != 2'b00;
  assign word_idx   = fetch_pc[OFF_BITS-1:2];
  assign line_word  = line_buf[{word_idx, 5'b00000} +: 32];
  assign has_entry  = count != '0;
  assign pop        = has_entry && bus.in_ready;
  // A misaligned PC produces one poisoned entry instead of a line lookup.
  assign push       = !bus.in_redirect && !halted && (misaligned || hit) &&
                      ((count < DEPTH_CNT) || pop);
  assign push_instr = misaligned ? NOP_INSTR : line_word;
  assign push_exc   = misaligned ? 3'b001 : 3'b000;
  assign install    = (state == S_REQ) && bus.in_mem_ready && !bus.in_redirect;
  assign start_req  = (state == S_IDLE) && (state_next == S_REQ);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!bus.in_redirect && !hit && !halted && !misaligned) state_next = S_REQ;
      end
      S_REQ: begin
        if (bus.in_redirect)       state_next = bus.in_mem_ready ? S_IDLE : S_DISCARD;
        else if (bus.in_mem_ready) state_next = S_IDLE;
      end
      S_DISCARD: begin
        if (bus.in_mem_ready) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // The line buffer survives redirects so a branch back into the current line needs no request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc   <= INIT_ADDR;
      req_addr   <= '0;
      line_buf   <= '0;
      line_tag   <= '0;
      line_valid <= 1'b0;
      halted     <= 1'b0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
    end else begin
      if (start_req) req_addr <= {fetch_pc[31:OFF_BITS], {OFF_BITS{1'b0}}};
      if (install) begin
        line_buf   <= bus.in_mem_read_data;
        line_tag   <= req_addr[31:OFF_BITS];
        line_valid <= 1'b1;
      end
      if (bus.in_redirect) begin
        fetch_pc <= bus.in_redirect_pc;
        halted   <= 1'b0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
          if (misaligned) halted   <= 1'b1;
          else            fetch_pc <= fetch_pc + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + PTR_ONE;
        if (push && !pop)      count <= count + CNT_ONE;
        else if (!push && pop) count <= count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr]    <= fetch_pc;
      q_instr[wr_ptr] <= push_instr;
      q_exc[wr_ptr]   <= push_exc;
    end
  end

  assign bus.out_valid            = has_entry;
  assign bus.out_PC               = has_entry ? q_pc[rd_ptr]    : 32'h0;
  assign bus.out_instruction      = has_entry ? q_instr[rd_ptr] : 32'h0;
  assign bus.out_exception_vector = has_entry ? q_exc[rd_ptr]   : 3'b000;
  assign bus.out_busy             = state != S_IDLE;
  assign bus.out_mem_read_en      = state != S_IDLE;
  assign bus.out_mem_addr         = req_addr;
  assign bus.out_mem_write_en     = 1'b0;
  assign bus.out_mem_write_data   = '0;
endmodule
